// File: rtl/lbp_pkg.sv
// Shared LBP pipeline definitions. The mapper, histogram and feature stages all import this.
package lbp_pkg;

  localparam int unsigned NUM_UNIFORM_BINS = 59;
  localparam int unsigned LBP_LABEL_W      = 8;
  localparam int unsigned BIN_IDX_W        = 6;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DUMP  = 1'b1
  } lbp_state_e;

endpackage

// File: rtl/lbp_bin_array.sv
// Register file of histogram bin counters.
// Each bin has its own increment/clear decode. The read port is a combinational mux.
module lbp_bin_array
  import lbp_pkg::*;
#(
  parameter int unsigned NUM_BINS = NUM_UNIFORM_BINS,
  parameter int unsigned COUNT_W  = 7,
  parameter int unsigned IDX_W    = BIN_IDX_W
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_inc_en,
  input  logic [IDX_W-1:0]   i_inc_idx,
  input  logic               i_clr_en,
  input  logic [IDX_W-1:0]   i_clr_idx,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic [COUNT_W-1:0] o_rd_data
);

  logic [COUNT_W-1:0] r_bins [NUM_BINS];
  logic [COUNT_W-1:0] w_rd_data;

  always_ff @(posedge i_clock) begin
    for (int i = 0; i < NUM_BINS; i++) begin
      if (i_reset) begin
        r_bins[i] <= '0;
      end else if (i_clr_en && (i_clr_idx == IDX_W'(i))) begin
        r_bins[i] <= '0;
      end else if (i_inc_en && (i_inc_idx == IDX_W'(i))) begin
        r_bins[i] <= r_bins[i] + COUNT_W'(1);
      end
    end
  end

  // Index values beyond NUM_BINS-1 read back as zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      if (i_rd_idx == IDX_W'(i)) begin
        w_rd_data = r_bins[i];
      end
    end
  end

  assign o_rd_data = w_rd_data;

endmodule

// File: rtl/lbp_cell_histogram.sv
// Accumulates a per-cell histogram of uniform LBP labels.
// The histogram is streamed out bin by bin, and each bin is cleared as it is sent.
module lbp_cell_histogram
  import lbp_pkg::*;
#(
  parameter int unsigned NUM_BINS    = NUM_UNIFORM_BINS,
  parameter int unsigned CELL_PIXELS = 64,
  parameter int unsigned COUNT_W     = $clog2(CELL_PIXELS + 1),
  parameter int unsigned IDX_W       = $clog2(NUM_BINS)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [LBP_LABEL_W-1:0] i_label_in,
  input  logic                   i_label_valid,
  output logic                   o_label_ready,
  input  logic                   i_cell_flush,
  output logic                   o_bin_valid,
  input  logic                   i_bin_ready,
  output logic [IDX_W-1:0]       o_bin_index,
  output logic [COUNT_W-1:0]     o_bin_count,
  output logic                   o_bin_last,
  output logic                   o_err_label
);

  lbp_state_e         r_state;
  lbp_state_e         w_state_d;
  logic [COUNT_W-1:0] r_pixel_cnt;
  logic [IDX_W-1:0]   r_rd_ptr;
  logic               r_err_label;

  logic               w_accept;
  logic               w_in_range;
  logic               w_xfer;
  logic               w_last;
  logic [COUNT_W-1:0] w_rd_data;

  assign w_accept   = i_label_valid && (r_state == ST_ACCUM);
  assign w_in_range = i_label_in < LBP_LABEL_W'(NUM_BINS);
  assign w_last     = r_rd_ptr == IDX_W'(NUM_BINS - 1);
  assign w_xfer     = (r_state == ST_DUMP) && i_bin_ready;

  lbp_bin_array #(
    .NUM_BINS (NUM_BINS),
    .COUNT_W  (COUNT_W),
    .IDX_W    (IDX_W)
  ) u_bins (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_inc_en  (w_accept && w_in_range),
    .i_inc_idx (i_label_in[IDX_W-1:0]),
    .i_clr_en  (w_xfer),
    .i_clr_idx (r_rd_ptr),
    .i_rd_idx  (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_ACCUM: begin
        // A flush on the same cycle as an accept counts that label before the dump starts.
        if (w_accept && (r_pixel_cnt == COUNT_W'(CELL_PIXELS - 1))) begin
          w_state_d = ST_DUMP;
        end else if (i_cell_flush && ((r_pixel_cnt != '0) || w_accept)) begin
          w_state_d = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (w_xfer && w_last) begin
          w_state_d = ST_ACCUM;
        end
      end
      default: w_state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_ACCUM;
      r_pixel_cnt <= '0;
      r_rd_ptr    <= '0;
      r_err_label <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_pixel_cnt <= r_pixel_cnt + COUNT_W'(1);
        if (!w_in_range) begin
          r_err_label <= 1'b1;
        end
      end
      if (w_xfer) begin
        if (w_last) begin
          r_rd_ptr    <= '0;
          r_pixel_cnt <= '0;
        end else begin
          r_rd_ptr <= r_rd_ptr + IDX_W'(1);
        end
      end
    end
  end

  assign o_label_ready = (r_state == ST_ACCUM);
  assign o_bin_valid   = (r_state == ST_DUMP);
  assign o_bin_index   = r_rd_ptr;
  assign o_bin_count   = (r_state == ST_DUMP) ? w_rd_data : '0;
  assign o_bin_last    = (r_state == ST_DUMP) && w_last;
  assign o_err_label   = r_err_label;

endmodule

// File: tb/tb_lbp_cell_histogram.sv
// Scoreboard bench for lbp_cell_histogram: directed cells push their expected dumps into a queue.
// A negedge monitor pops and compares each bin transfer.
module tb_lbp_cell_histogram;
  import lbp_pkg::*;

  localparam int NB = 59;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] label_in;
  logic       label_valid;
  logic       label_ready;
  logic       cell_flush;
  logic       bin_valid;
  logic       bin_ready;
  logic [5:0] bin_index;
  logic [6:0] bin_count;
  logic       bin_last;
  logic       err_label;

  typedef struct {
    int idx;
    int cnt;
    bit last;
    int sum;
  } bin_t;

  bin_t exp_q[$];
  int   exp_bins[NB];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   dump_sum = 0;

  always #5 clock = ~clock;

  lbp_cell_histogram dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_label_in    (label_in),
    .i_label_valid (label_valid),
    .o_label_ready (label_ready),
    .i_cell_flush  (cell_flush),
    .o_bin_valid   (bin_valid),
    .i_bin_ready   (bin_ready),
    .o_bin_index   (bin_index),
    .o_bin_count   (bin_count),
    .o_bin_last    (bin_last),
    .o_err_label   (err_label)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NB; i++) exp_bins[i] = 0;
  endtask

  task automatic push_exp(input int sum);
    bin_t e;
    for (int i = 0; i < NB; i++) begin
      e.idx  = i;
      e.cnt  = exp_bins[i];
      e.last = (i == NB - 1);
      e.sum  = sum;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int lbl, input int n, input bit flush_last);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!label_ready && t < 300) begin
        tick();
        t++;
      end
      if (!label_ready) check("label_ready_timeout", 0, 1);
      label_in    = 8'(lbl);
      label_valid = 1'b1;
      cell_flush  = flush_last && (k == n - 1);
      tick();
    end
    label_valid = 1'b0;
    cell_flush  = 1'b0;
  endtask

  task automatic wait_dump(input bit toggle);
    int t = 0;
    bin_ready = 1'b1;
    while (exp_q.size() != 0 && t < 1000) begin
      tick();
      if (toggle) bin_ready = ~bin_ready;
      t++;
    end
    if (exp_q.size() != 0) check("dump_timeout", exp_q.size(), 0);
    bin_ready = 1'b1;
    check("label_ready_after_last", int'(label_ready), 1);
    check("bin_valid_after_last", int'(bin_valid), 0);
  endtask

  // Monitor: compares transfers and checks that outputs hold steady while stalled.
  bit       prev_stall = 1'b0;
  int       prev_idx, prev_cnt, prev_last;
  always @(negedge clock) begin
    if (!reset && bin_valid) begin
      if (prev_stall) begin
        check("hold_index", int'(bin_index), prev_idx);
        check("hold_count", int'(bin_count), prev_cnt);
        check("hold_last", int'(bin_last), prev_last);
      end
      check("label_ready_in_dump", int'(label_ready), 0);
      if (bin_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bin", int'(bin_index), -1);
        end else begin
          bin_t e;
          e = exp_q.pop_front();
          check("bin_index", int'(bin_index), e.idx);
          check("bin_count", int'(bin_count), e.cnt);
          check("bin_last", int'(bin_last), int'(e.last));
          dump_sum += int'(bin_count);
          if (e.last) begin
            check("dump_sum", dump_sum, e.sum);
            dump_sum = 0;
          end
        end
      end
      prev_stall = !bin_ready;
      prev_idx   = int'(bin_index);
      prev_cnt   = int'(bin_count);
      prev_last  = int'(bin_last);
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got 0, expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    label_in    = '0;
    label_valid = 1'b0;
    cell_flush  = 1'b0;
    bin_ready   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_label_ready", int'(label_ready), 1);
    check("rst_bin_valid", int'(bin_valid), 0);
    check("rst_bin_index", int'(bin_index), 0);
    check("rst_bin_count", int'(bin_count), 0);
    check("rst_bin_last", int'(bin_last), 0);
    check("rst_err_label", int'(err_label), 0);

    // Case 1: 64 x label 5.
    clear_exp();
    exp_bins[5] = 64;
    push_exp(64);
    send(5, 64, 1'b0);
    wait_dump(1'b0);

    // Case 2: labels 0..58 then 0..4, with first-bin latency check.
    clear_exp();
    for (int i = 0; i < NB; i++) exp_bins[i] = (i < 5) ? 2 : 1;
    push_exp(64);
    for (int i = 0; i < NB; i++) send(i, 1, 1'b0);
    for (int i = 0; i < 4; i++) send(i, 1, 1'b0);
    check("no_valid_before_64th", int'(bin_valid), 0);
    send(4, 1, 1'b0);
    check("valid_after_64th", int'(bin_valid), 1);
    check("ready_low_after_64th", int'(label_ready), 0);
    wait_dump(1'b0);

    // Case 3: same cell, consumer toggling ready.
    push_exp(64);
    for (int i = 0; i < NB; i++) send(i, 1, 1'b0);
    for (int i = 0; i < 5; i++) send(i, 1, 1'b0);
    wait_dump(1'b1);

    // Case 4: partial cell flushes.
    clear_exp();
    exp_bins[7] = 10;
    push_exp(10);
    send(7, 10, 1'b0);
    check("no_dump_before_flush", int'(bin_valid), 0);
    cell_flush = 1'b1;
    tick();
    cell_flush = 1'b0;
    check("flush_starts_dump", int'(bin_valid), 1);
    wait_dump(1'b0);
    cell_flush = 1'b1;
    tick();
    cell_flush = 1'b0;
    check("empty_flush_no_dump", int'(bin_valid), 0);
    check("empty_flush_ready", int'(label_ready), 1);
    tick();
    check("empty_flush_no_dump_2", int'(bin_valid), 0);
    push_exp(10);
    send(7, 10, 1'b1);
    check("flush_with_accept_dump", int'(bin_valid), 1);
    wait_dump(1'b0);

    // Case 5: out-of-range label.
    clear_exp();
    exp_bins[3] = 63;
    push_exp(63);
    send(200, 1, 1'b0);
    check("err_set", int'(err_label), 1);
    send(3, 62, 1'b0);
    check("no_dump_at_63", int'(bin_valid), 0);
    send(3, 1, 1'b0);
    check("dump_after_64_accepts", int'(bin_valid), 1);
    wait_dump(1'b0);
    check("err_sticky", int'(err_label), 1);

    // Case 6: reset in the middle of a dump.
    clear_exp();
    exp_bins[9] = 64;
    push_exp(64);
    send(9, 64, 1'b0);
    begin
      int t = 0;
      while (!(bin_valid && bin_index == 6'd20) && t < 200) begin
        tick();
        t++;
      end
      check("reached_index_20", int'(bin_index), 20);
    end
    bin_ready = 1'b0;
    reset     = 1'b1;
    exp_q.delete();
    tick();
    reset    = 1'b0;
    dump_sum = 0;
    check("midrst_bin_valid", int'(bin_valid), 0);
    check("midrst_label_ready", int'(label_ready), 1);
    check("midrst_bin_index", int'(bin_index), 0);
    check("midrst_err_label", int'(err_label), 0);
    clear_exp();
    exp_bins[1] = 64;
    push_exp(64);
    send(1, 64, 1'b0);
    wait_dump(1'b0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
